// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and address helper
// for the LBP scan sequencer.
package lbp_pkg;

  localparam int W     = 128;
  localparam int H     = 128;
  localparam int LOG2W = $clog2(W);
  localparam int RW    = $clog2(H);
  localparam int AW    = RW + LOG2W;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    SLIDE,
    EMIT,
    DONE
  } state_e;

  typedef logic [3:0] slot_t;

  localparam slot_t SLOT_CENTER = 4'd4;
  localparam slot_t SLOT_LAST   = 4'd8;
  localparam slot_t SLOT_RT     = 4'd2;
  localparam slot_t SLOT_RM     = 4'd5;
  localparam slot_t SLOT_RB     = 4'd8;
  localparam slot_t SLIDE_LAST  = 4'd2;

  // W is a power of two, so {row, col} is row*W + col.
  function automatic logic [AW-1:0] pix_addr(
    input logic [RW-1:0]    row,
    input logic [LOG2W-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/lbp_scan_ctrl_if.sv
// Gray-memory read, window control and LBP write strobes
// between the scan sequencer and its datapath.
interface lbp_scan_ctrl_if
  import lbp_pkg::*;
();

  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          win_wr;
  slot_t         win_slot;
  logic          win_shift;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic          finish;

  modport master (
    input  gray_ready,
    output gray_req,
    output gray_addr,
    output win_wr,
    output win_slot,
    output win_shift,
    output lbp_valid,
    output lbp_addr,
    output finish
  );

  modport slave (
    output gray_ready,
    input  gray_req,
    input  gray_addr,
    input  win_wr,
    input  win_slot,
    input  win_shift,
    input  lbp_valid,
    input  lbp_addr,
    input  finish
  );

endinterface

// File: rtl/lbp_addr_gen.sv
// Maps center (r, c) and fetch phase to a gray address
// and window slot; shared by the full fill and the slide.
module lbp_addr_gen
  import lbp_pkg::*;
(
  input  logic [RW-1:0]    r,
  input  logic [LOG2W-1:0] c,
  input  slot_t            ph,
  input  logic             slide,
  output logic [AW-1:0]    addr,
  output slot_t            slot
);

  localparam logic [RW-1:0]    R1 = RW'(1);
  localparam logic [LOG2W-1:0] C1 = LOG2W'(1);

  logic [RW-1:0]    row;
  logic [LOG2W-1:0] col;

  always_comb begin
    row  = r;
    col  = c;
    slot = SLOT_CENTER;
    if (slide) begin
      col = c + C1;
      unique case (ph)
        4'd0: begin
          row  = r - R1;
          slot = SLOT_RT;
        end
        4'd1: slot = SLOT_RM;
        4'd2: begin
          row  = r + R1;
          slot = SLOT_RB;
        end
        default: ;
      endcase
    end else begin
      slot = ph;
      unique case (1'b1)
        ph < 4'd3: row = r - R1;
        ph > 4'd5: row = r + R1;
        default: ;
      endcase
      unique case (ph)
        4'd0, 4'd3, 4'd6: col = c - C1;
        4'd2, 4'd5, 4'd8: col = c + C1;
        default: ;
      endcase
    end
  end

  assign addr = pix_addr(row, col);

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Raster scan sequencer: 9-read fill at row start, then
// a 3-read slide per pixel, one LBP write strobe each.
module lbp_scan_ctrl
  import lbp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  lbp_scan_ctrl_if.master  bus
);

  localparam logic [RW-1:0]    R1     = RW'(1);
  localparam logic [RW-1:0]    R_LAST = RW'(H - 2);
  localparam logic [LOG2W-1:0] C1     = LOG2W'(1);
  localparam logic [LOG2W-1:0] C_LAST = LOG2W'(W - 2);
  localparam slot_t            PH1    = 4'd1;

  state_e           st_q, st_d;
  logic [RW-1:0]    r_q, r_d;
  logic [LOG2W-1:0] c_q, c_d;
  slot_t            ph_q, ph_d;

  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  slot_t         slot_q, slot_d;
  logic          shift_q, shift_d;
  logic          lv_q, lv_d;
  logic [AW-1:0] laddr_q, laddr_d;
  logic          fin_q, fin_d;

  logic          fetch;
  logic [AW-1:0] ag_addr;
  slot_t         ag_slot;

  // A phase only advances once its read was actually issued.
  always_comb begin
    st_d = st_q;
    r_d  = r_q;
    c_d  = c_q;
    ph_d = ph_q;
    unique case (st_q)
      IDLE: begin
        if (bus.gray_ready) begin
          st_d = FILL;
          ph_d = '0;
        end
      end
      FILL: begin
        if (req_q) begin
          if (ph_q == SLOT_LAST) st_d = EMIT;
          else ph_d = ph_q + PH1;
        end
      end
      SLIDE: begin
        if (req_q) begin
          if (ph_q == SLIDE_LAST) st_d = EMIT;
          else ph_d = ph_q + PH1;
        end
      end
      EMIT: begin
        ph_d = '0;
        if (c_q < C_LAST) begin
          c_d  = c_q + C1;
          st_d = SLIDE;
        end else if (r_q < R_LAST) begin
          r_d  = r_q + R1;
          c_d  = C1;
          st_d = FILL;
        end else begin
          st_d = DONE;
        end
      end
      DONE: ;
      default: st_d = IDLE;
    endcase
  end

  lbp_addr_gen u_addr_gen (
    .r     (r_d),
    .c     (c_d),
    .ph    (ph_d),
    .slide (st_d == SLIDE),
    .addr  (ag_addr),
    .slot  (ag_slot)
  );

  // Outputs are registered for the cycle spent in st_d.
  always_comb begin
    fetch   = (st_d == FILL) || (st_d == SLIDE);
    req_d   = fetch && bus.gray_ready;
    wr_d    = req_d;
    addr_d  = fetch ? ag_addr : '0;
    slot_d  = fetch ? ag_slot : '0;
    lv_d    = (st_d == EMIT);
    shift_d = lv_d && (c_d < C_LAST);
    laddr_d = lv_d ? pix_addr(r_d, c_d) : laddr_q;
    fin_d   = (st_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= IDLE;
      r_q     <= R1;
      c_q     <= C1;
      ph_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      slot_q  <= '0;
      shift_q <= 1'b0;
      lv_q    <= 1'b0;
      laddr_q <= '0;
      fin_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ph_q    <= ph_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      lv_q    <= lv_d;
      laddr_q <= laddr_d;
      fin_q   <= fin_d;
    end
  end

  assign bus.gray_req  = req_q;
  assign bus.gray_addr = addr_q;
  assign bus.win_wr    = wr_q;
  assign bus.win_slot  = slot_q;
  assign bus.win_shift = shift_q;
  assign bus.lbp_valid = lv_q;
  assign bus.lbp_addr  = laddr_q;
  assign bus.finish    = fin_q;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Scoreboard bench for lbp_scan_ctrl with a behavioral
// window/LBP datapath and gray image.
module tb_lbp_scan_ctrl;
  import lbp_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  lbp_scan_ctrl_if bus ();

  lbp_scan_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_pulse = 0;
  bit mon_en = 1'b0;

  logic [17:0] exp_rd[$];
  logic [14:0] exp_lbp[$];
  logic [8:0][7:0] win;
  logic [7:0] lbp_mem [W*H];

  localparam logic [17:0] D1 [12] = '{
    {14'd0, 4'd0},   {14'd1, 4'd1},   {14'd2, 4'd2},
    {14'd128, 4'd3}, {14'd129, 4'd4}, {14'd130, 4'd5},
    {14'd256, 4'd6}, {14'd257, 4'd7}, {14'd258, 4'd8},
    {14'd3, 4'd2},   {14'd131, 4'd5}, {14'd259, 4'd8}
  };
  localparam logic [17:0] D2 [9] = '{
    {14'd128, 4'd0}, {14'd129, 4'd1}, {14'd130, 4'd2},
    {14'd256, 4'd3}, {14'd257, 4'd4}, {14'd258, 4'd5},
    {14'd384, 4'd6}, {14'd385, 4'd7}, {14'd386, 4'd8}
  };

  task automatic chk(input string nm, input int act,
                     input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, req);
  endtask

  function automatic logic [7:0] pix(input int a);
    int unsigned t;
    t = 32'(a) * 32'd40503;
    return t[15:8] ^ t[7:0];
  endfunction

  function automatic logic [7:0] lbp_code(
    input logic [8:0][7:0] g
  );
    logic [7:0] v;
    int k;
    v = '0;
    k = 0;
    for (int s = 0; s < 9; s++) begin
      if (s != 4) begin
        v[k] = (g[s] >= g[4]);
        k++;
      end
    end
    return v;
  endfunction

  function automatic logic [7:0] gold(input int a);
    int r, c;
    logic [8:0][7:0] g;
    r = a / W;
    c = a % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1)
      return 8'd0;
    for (int s = 0; s < 9; s++)
      g[s] = pix((r-1+s/3)*W + c-1+s%3);
    return lbp_code(g);
  endfunction

  task automatic push_full();
    for (int r = 1; r <= H-2; r++) begin
      for (int p = 0; p < 9; p++)
        exp_rd.push_back({14'((r-1+p/3)*W + p%3), 4'(p)});
      exp_lbp.push_back({14'(r*W + 1), 1'b1});
      for (int c = 2; c <= W-2; c++) begin
        for (int k = 0; k < 3; k++)
          exp_rd.push_back({14'((r-1+k)*W + c+1),
                            4'(2 + 3*k)});
        exp_lbp.push_back({14'(r*W + c), c < W-2});
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req"}, int'(bus.gray_req), 0);
    chk({tag, "_addr"}, int'(bus.gray_addr), 0);
    chk({tag, "_wr"}, int'(bus.win_wr), 0);
    chk({tag, "_slot"}, int'(bus.win_slot), 0);
    chk({tag, "_shift"}, int'(bus.win_shift), 0);
    chk({tag, "_lv"}, int'(bus.lbp_valid), 0);
    chk({tag, "_laddr"}, int'(bus.lbp_addr), 0);
    chk({tag, "_fin"}, int'(bus.finish), 0);
  endtask

  // Datapath model plus scoreboard monitor.
  always @(negedge clk) begin
    logic [17:0] er;
    logic [14:0] el;
    if (bus.lbp_valid === 1'b1)
      lbp_mem[bus.lbp_addr] = lbp_code(win);
    if (bus.win_shift === 1'b1) begin
      win[0] = win[1]; win[1] = win[2];
      win[3] = win[4]; win[4] = win[5];
      win[6] = win[7]; win[7] = win[8];
    end
    if (bus.win_wr === 1'b1 && bus.win_slot < 4'd9)
      win[bus.win_slot] = pix(int'(bus.gray_addr));
    if (mon_en) begin
      chk("strobe_excl",
          int'({bus.win_wr != bus.gray_req,
                bus.win_shift & ~bus.lbp_valid}), 0);
      if (bus.gray_req) begin
        if (exp_rd.size() == 0) begin
          chk("rd_extra", int'(bus.gray_addr), -1);
        end else begin
          er = exp_rd.pop_front();
          chk("rd_addr_slot",
              int'({bus.gray_addr, bus.win_slot}), int'(er));
        end
      end
      if (bus.lbp_valid) begin
        n_pulse++;
        if (exp_lbp.size() == 0) begin
          chk("lbp_extra", int'(bus.lbp_addr), -1);
        end else begin
          el = exp_lbp.pop_front();
          chk("lbp_addr_shift",
              int'({bus.lbp_addr, bus.win_shift}), int'(el));
        end
      end
    end
  end

  initial begin
    int t;
    int cyc;
    bus.gray_ready = 1'b0;
    #3 reset = 1'b1;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    foreach (D1[i]) exp_rd.push_back(D1[i]);
    exp_lbp.push_back({14'd129, 1'b1});
    exp_lbp.push_back({14'd130, 1'b1});
    mon_en = 1'b1;
    bus.gray_ready = 1'b1;

    // Stall right after the first slide read (addr 3).
    for (t = 0; t < 200 &&
         !(bus.gray_req && bus.gray_addr == 14'd3); t++) begin
      @(posedge clk); #1;
    end
    chk("wait_slide", int'(t < 200), 1);
    bus.gray_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("stall_quiet",
          int'({bus.gray_req, bus.win_wr}), 0);
    end
    bus.gray_ready = 1'b1;
    for (t = 0; t < 200 &&
         (exp_rd.size() != 0 || exp_lbp.size() != 0); t++) begin
      @(posedge clk); #1;
    end
    chk("drain_first", int'(t < 200), 1);
    mon_en = 1'b0;

    // Row wrap after the last center of row 1.
    for (t = 0; t < 1000 &&
         !(bus.lbp_valid && bus.lbp_addr == 14'd254); t++) begin
      @(posedge clk); #1;
    end
    chk("wait_wrap", int'(t < 1000), 1);
    chk("wrap_noshift", int'(bus.win_shift), 0);
    @(posedge clk); #1;
    foreach (D2[i]) exp_rd.push_back(D2[i]);
    exp_lbp.push_back({14'd257, 1'b1});
    mon_en = 1'b1;
    for (t = 0; t < 200 &&
         (exp_rd.size() != 0 || exp_lbp.size() != 0); t++) begin
      @(posedge clk); #1;
    end
    chk("drain_wrap", int'(t < 200), 1);
    mon_en = 1'b0;

    // Asynchronous reset at the start of row 3's fill.
    for (t = 0; t < 2000 && !(bus.gray_req &&
         bus.win_slot == 4'd0 && bus.gray_addr == 14'd256);
         t++) begin
      @(posedge clk); #1;
    end
    chk("wait_row3", int'(t < 2000), 1);
    #2 reset = 1'b1;
    #1 check_zero("async");
    bus.gray_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < W*H; i++) lbp_mem[i] = 8'd0;
    exp_rd.delete();
    exp_lbp.delete();
    n_pulse = 0;
    push_full();
    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_req", int'(bus.gray_req), 0);
    mon_en = 1'b1;
    bus.gray_ready = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 70000) begin
      @(negedge clk);
      cyc++;
      if (bus.finish) break;
    end
    chk("finish_cycle", cyc, 64261);
    chk("rd_left", exp_rd.size(), 0);
    chk("lbp_left", exp_lbp.size(), 0);
    chk("pulses", n_pulse, 15876);
    for (int a = 0; a < W*H; a++)
      chk("image", int'(lbp_mem[a]), int'(gold(a)));

    repeat (100) begin
      bus.gray_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("done_hold", int'({bus.finish, bus.gray_req,
                             bus.lbp_valid}), 4);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
